// File: rtl/dmem_lsu.sv
// Data memory with RV32I load/store lane handling and a one-entry registered response.
// Requests are accepted when the response slot is empty or being drained in the same cycle.
//
// state   | meaning
// S_EMPTY | no response held, rsp_valid=0
// S_FULL  | response held in rsp_*, waiting for rsp_ready
module dmem_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int WI_W  = ADDR_W - 2;

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       state;
    logic [31:0]      mem [DEPTH_WORDS];
    logic             accept;
    logic             mis;
    logic             illegal;
    logic             oor;
    logic             err;
    logic             wr_en;
    logic [WI_W-1:0]  word_idx;
    logic [IDX_W-1:0] mem_idx;
    logic [1:0]       lane;
    logic [3:0]       be;
    logic [31:0]      wd;
    logic [31:0]      rd_word;
    logic [31:0]      ld_data;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;

    assign rsp_valid = (state == S_FULL);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    assign word_idx = req_addr[ADDR_W-1:2];
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign lane     = req_addr[1:0];

    // Any set bit above the memory index width puts the word past the end.
    generate
        if (WI_W > IDX_W) begin : g_oor
            assign oor = |word_idx[WI_W-1:IDX_W];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    always_comb begin
        mis     = 1'b0;
        illegal = 1'b0;
        be      = 4'b0000;
        wd      = req_wdata;
        case (req_funct3)
            3'b000: begin
                be = 4'b0001 << lane;
                wd = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                mis = lane[0];
                be  = lane[1] ? 4'b1100 : 4'b0011;
                wd  = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                mis = (lane != 2'b00);
                be  = 4'b1111;
            end
            3'b100: illegal = req_we;
            3'b101: begin
                illegal = req_we;
                mis     = lane[0];
            end
            default: illegal = 1'b1;
        endcase
        err   = mis || illegal || oor;
        wr_en = accept && req_we && !err;
    end

    always_comb begin
        rd_word = mem[mem_idx];
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    // Memory has no reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[mem_idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_EMPTY;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            state     <= S_FULL;
            rsp_err   <= err;
            rsp_rdata <= (req_we || err) ? 32'h0 : ld_data;
        end else if (rsp_ready) begin
            state     <= S_EMPTY;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: the driver queues expected responses on accept,
// the monitor pops and compares whenever a new response is presented.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [11:0] req_addr = 12'h000;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_lsu #(.DEPTH_WORDS(256), .ADDR_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [11:0] a;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a response is compared on its first cycle, then must stay stable while stalled.
    logic        held = 1'b0;
    logic [31:0] held_rdata;
    logic        held_err;
    exp_t        cur;

    always @(negedge clk) begin
        if (rst || !rsp_valid) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stable_rdata", rsp_rdata, held_rdata);
                check("stable_err", {31'b0, rsp_err}, {31'b0, held_err});
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h err %b with nothing expected", rsp_rdata, rsp_err);
            end else begin
                cur = sb.pop_front();
                check("latency", cyc, cur.cyc + 1);
                check("rdata", rsp_rdata, cur.rdata);
                check("err", {31'b0, rsp_err}, {31'b0, cur.err});
            end
            if (rsp_ready) begin
                held = 1'b0;
            end else begin
                check("stall_req_ready", {31'b0, req_ready}, 32'h0);
                held       = 1'b1;
                held_rdata = rsp_rdata;
                held_err   = rsp_err;
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int n;
        n          = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready %b after %0d cycles, required 1", req_ready, n);
        end else begin
            sb.push_back('{er, ee, cyc});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        // we, funct3, addr, wdata, expected rdata, expected err
        vecs.push_back('{1'b1, 3'b010, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 12'h013, 32'h12345680, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 12'h013, 32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 12'h013, 32'h0,        32'h00000080, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 12'h010, 32'h0,        32'h80ADBEEF, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 12'h012, 32'h0,        32'hFFFF80AD, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 12'h010, 32'h0,        32'h0000BEEF, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 12'h010, 32'h0,        32'hFFFFFFEF, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 12'h011, 32'h0,        32'h000000BE, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 12'h020, 32'hCAFEF00D, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 3'b001, 12'h022, 32'hABCD1234, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 12'h020, 32'h0,        32'h1234F00D, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 12'h021, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 3'b001, 12'h020, 32'h00005678, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 12'h020, 32'h0,        32'h00005678, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 12'h020, 32'h0,        32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 12'h000, 32'h01234567, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 12'h001, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 12'h400, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 12'h400, 32'h55555555, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 3'b100, 12'h000, 32'h00000099, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'b011, 12'h000, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 12'h002, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 12'hFFC, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 12'h000, 32'h0,        32'h01234567, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 12'h3FC, 32'hA5A5A5A5, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 12'h3FC, 32'h0,        32'hA5A5A5A5, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 12'h040, 32'h11223344, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 12'h040, 32'h0,        32'h11223344, 1'b0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].we, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].er, vecs[i].ee);
        end

        // Back-to-back loads while the consumer stalls for two cycles.
        fork
            begin
                issue(1'b0, 3'b010, 12'h010, 32'h0, 32'h80ADBEEF, 1'b0);
                issue(1'b0, 3'b010, 12'h020, 32'h0, 32'h12345678, 1'b0);
                issue(1'b0, 3'b100, 12'h013, 32'h0, 32'h00000080, 1'b0);
                issue(1'b0, 3'b010, 12'h000, 32'h0, 32'h01234567, 1'b0);
            end
            begin
                logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
                foreach (pat[k]) begin
                    @(posedge clk);
                    #2;
                    rsp_ready = pat[k];
                end
            end
        join
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset while a response is held and a store to 0x040 is pending.
        rsp_ready = 1'b0;
        issue(1'b0, 3'b010, 12'h040, 32'h0, 32'h11223344, 1'b0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 12'h040;
        req_wdata  = 32'hAAAAAAAA;
        #2;
        rst = 1'b1;
        #1;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        sb.delete();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b0;
        issue(1'b0, 3'b010, 12'h040, 32'h0, 32'h11223344, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            n++;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        check("sb_drained", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
